// File: rtl/hazard_ctrl_pkg.sv
// Shared CPU constants for the pipeline hazard controller: FSM encoding, mult latency
// default, ALUCtrl mult code and the load-use detection rule.
package hazard_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MUL_WAIT = 1'b1
    } hz_state_e;

    localparam int unsigned MUL_LAT_DEFAULT = 4;
    localparam int unsigned CNT_W_DEFAULT   = 16;
    localparam logic [3:0]  ALU_CTRL_MULT   = 4'd13;

    // Register 0 is hard-wired, so a load targeting it never creates a dependency.
    function automatic logic load_use_hit(
        input logic       ld,
        input logic [4:0] wa,
        input logic [4:0] r1,
        input logic [4:0] r2
    );
        return ld && (wa != 5'd0) && ((wa == r1) || (wa == r2));
    endfunction

endpackage

// File: rtl/hazard_ctrl_perf_counter.sv
// Saturating event counter with enable; holds at all-ones once full.
module perf_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and multi-cycle
// mult hold in EX, plus saturating stall/flush performance counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = MUL_LAT_DEFAULT,
    parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_read1_i,
    input  logic [4:0]       id_read2_i,
    input  logic             ex_mem_read_i,
    input  logic [4:0]       ex_write_addr_i,
    input  logic             ex_mult_i,
    input  logic             mem_branch_taken_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             idex_write_o,
    output logic             ifid_flush_o,
    output logic             idex_flush_o,
    output logic             exmem_flush_o,
    output logic             mul_busy_o,
    output logic             mul_done_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam bit         MUL_STALLS = (MUL_LAT > 1);
    localparam logic [3:0] CNT_LOAD   = (MUL_LAT > 1) ? 4'(MUL_LAT - 2) : 4'd0;

    hz_state_e  state, nxt_state;
    logic [3:0] cnt, nxt_cnt;
    logic       stall_cycle;

    always_comb begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        idex_write_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_flush_o  = 1'b0;
        exmem_flush_o = 1'b0;
        mul_busy_o    = 1'b0;
        mul_done_o    = 1'b0;
        nxt_state     = state;
        nxt_cnt       = cnt;

        // While reset is held the pipeline sees the plain no-hazard controls.
        if (!rst_i) begin
            nxt_state = RUN;
            nxt_cnt   = '0;
        end else if (mem_branch_taken_i) begin
            ifid_flush_o  = 1'b1;
            idex_flush_o  = 1'b1;
            exmem_flush_o = 1'b1;
            nxt_state     = RUN;
            nxt_cnt       = '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (ex_mult_i) begin
                        if (MUL_STALLS) begin
                            pc_write_o    = 1'b0;
                            ifid_write_o  = 1'b0;
                            idex_write_o  = 1'b0;
                            exmem_flush_o = 1'b1;
                            mul_busy_o    = 1'b1;
                            nxt_cnt       = CNT_LOAD;
                            nxt_state     = MUL_WAIT;
                        end else begin
                            mul_done_o = 1'b1;
                        end
                    end else if (load_use_hit(ex_mem_read_i, ex_write_addr_i,
                                              id_read1_i, id_read2_i)) begin
                        pc_write_o   = 1'b0;
                        ifid_write_o = 1'b0;
                        idex_flush_o = 1'b1;
                    end
                end
                MUL_WAIT: begin
                    if (cnt != 4'd0) begin
                        pc_write_o    = 1'b0;
                        ifid_write_o  = 1'b0;
                        idex_write_o  = 1'b0;
                        exmem_flush_o = 1'b1;
                        mul_busy_o    = 1'b1;
                        nxt_cnt       = cnt - 4'd1;
                    end else begin
                        mul_done_o = 1'b1;
                        nxt_state  = RUN;
                    end
                end
                default: begin
                    nxt_state = RUN;
                    nxt_cnt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= nxt_state;
            cnt   <= nxt_cnt;
        end
    end

    assign stall_cycle = ~pc_write_o;

    perf_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk_i),
        .rst_n (rst_i),
        .en    (stall_cycle),
        .count (stall_cnt_o)
    );

    perf_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk_i),
        .rst_n (rst_i),
        .en    (mem_branch_taken_i),
        .count (flush_cnt_o)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (MUL_LAT=4/CNT_W=16 and MUL_LAT=1/CNT_W=4) driven
// in lockstep and compared against a mult-residence-age reference model.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] r1, r2, wa;
    logic       ld, mult, br;

    logic        a_pc, a_ifid, a_idex, a_ifl, a_idfl, a_exfl, a_busy, a_done;
    logic [15:0] a_stall, a_flush;
    logic        b_pc, b_ifid, b_idex, b_ifl, b_idfl, b_exfl, b_busy, b_done;
    logic [3:0]  b_stall, b_flush;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: cycles the current mult has already spent in EX, and event counts.
    int age_a, age_b, mstall_a, mflush_a, mstall_b, mflush_b;

    always #5 clk = ~clk;

    hazard_ctrl #(.MUL_LAT(4), .CNT_W(16)) dut_a (
        .clk_i(clk), .rst_i(rst_n), .id_read1_i(r1), .id_read2_i(r2),
        .ex_mem_read_i(ld), .ex_write_addr_i(wa), .ex_mult_i(mult),
        .mem_branch_taken_i(br), .pc_write_o(a_pc), .ifid_write_o(a_ifid),
        .idex_write_o(a_idex), .ifid_flush_o(a_ifl), .idex_flush_o(a_idfl),
        .exmem_flush_o(a_exfl), .mul_busy_o(a_busy), .mul_done_o(a_done),
        .stall_cnt_o(a_stall), .flush_cnt_o(a_flush)
    );

    hazard_ctrl #(.MUL_LAT(1), .CNT_W(4)) dut_b (
        .clk_i(clk), .rst_i(rst_n), .id_read1_i(r1), .id_read2_i(r2),
        .ex_mem_read_i(ld), .ex_write_addr_i(wa), .ex_mult_i(mult),
        .mem_branch_taken_i(br), .pc_write_o(b_pc), .ifid_write_o(b_ifid),
        .idex_write_o(b_idex), .ifid_flush_o(b_ifl), .idex_flush_o(b_idfl),
        .exmem_flush_o(b_exfl), .mul_busy_o(b_busy), .mul_done_o(b_done),
        .stall_cnt_o(b_stall), .flush_cnt_o(b_flush)
    );

    // flags = {pc_write, ifid_write, idex_write, ifid_flush, idex_flush, exmem_flush, busy, done}
    typedef struct {
        logic [7:0] flags;
        bit         stall;
        int         age_nxt;
    } exp_t;

    function automatic exp_t model(int lat, int age, bit ld_v, bit [4:0] wa_v,
                                   bit [4:0] r1_v, bit [4:0] r2_v, bit mult_v, bit br_v);
        exp_t e;
        int   cur;
        e.flags   = 8'b1110_0000;
        e.age_nxt = age;
        if (br_v) begin
            e.flags   = 8'b1111_1100;
            e.age_nxt = 0;
        end else if (age > 0 || mult_v) begin
            cur = age + 1;
            if (cur >= lat) begin
                e.flags   = 8'b1110_0001;
                e.age_nxt = 0;
            end else begin
                e.flags   = 8'b0000_0110;
                e.age_nxt = cur;
            end
        end else if (ld_v && wa_v != 0 && (wa_v == r1_v || wa_v == r2_v)) begin
            e.flags = 8'b0010_1000;
        end
        e.stall = !e.flags[7];
        return e;
    endfunction

    function automatic int sat(int v, int w);
        int m = (1 << w) - 1;
        return (v > m) ? m : v;
    endfunction

    task automatic chk(string tag, int obs, int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] flags_a();
        return {a_pc, a_ifid, a_idex, a_ifl, a_idfl, a_exfl, a_busy, a_done};
    endfunction

    function automatic logic [7:0] flags_b();
        return {b_pc, b_ifid, b_idex, b_ifl, b_idfl, b_exfl, b_busy, b_done};
    endfunction

    task automatic model_reset();
        age_a = 0; age_b = 0;
        mstall_a = 0; mflush_a = 0; mstall_b = 0; mflush_b = 0;
    endtask

    task automatic set_in(bit [4:0] r1_v, bit [4:0] r2_v, bit ld_v, bit [4:0] wa_v,
                          bit mult_v, bit br_v);
        r1 = r1_v; r2 = r2_v; ld = ld_v; wa = wa_v; mult = mult_v; br = br_v;
    endtask

    // One pipeline cycle: drive at negedge, check combinational controls and counters, advance model.
    task automatic step(string tag, bit [4:0] r1_v, bit [4:0] r2_v, bit ld_v,
                        bit [4:0] wa_v, bit mult_v, bit br_v);
        exp_t ea, eb;
        @(negedge clk);
        set_in(r1_v, r2_v, ld_v, wa_v, mult_v, br_v);
        #1;
        ea = model(4, age_a, ld_v, wa_v, r1_v, r2_v, mult_v, br_v);
        eb = model(1, age_b, ld_v, wa_v, r1_v, r2_v, mult_v, br_v);
        chk({tag, "_a_ctl"},   int'(flags_a()), int'(ea.flags));
        chk({tag, "_a_stall"}, int'(a_stall),   mstall_a);
        chk({tag, "_a_flush"}, int'(a_flush),   mflush_a);
        chk({tag, "_b_ctl"},   int'(flags_b()), int'(eb.flags));
        chk({tag, "_b_stall"}, int'(b_stall),   mstall_b);
        chk({tag, "_b_flush"}, int'(b_flush),   mflush_b);
        age_a = ea.age_nxt;
        age_b = eb.age_nxt;
        if (ea.stall) mstall_a = sat(mstall_a + 1, 16);
        if (eb.stall) mstall_b = sat(mstall_b + 1, 4);
        if (br_v) begin
            mflush_a = sat(mflush_a + 1, 16);
            mflush_b = sat(mflush_b + 1, 4);
        end
    endtask

    task automatic apply_reset(string tag);
        @(negedge clk);
        rst_n = 1'b0;
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        model_reset();
        #1;
        chk({tag, "_a_ctl"},   int'(flags_a()), int'(8'b1110_0000));
        chk({tag, "_a_stall"}, int'(a_stall),   0);
        chk({tag, "_b_ctl"},   int'(flags_b()), int'(8'b1110_0000));
        chk({tag, "_b_flush"}, int'(b_flush),   0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        apply_reset("por");

        // Load-use on $8, then normal flow; one stall recorded.
        step("lu",      5'd8, 5'd3, 1'b1, 5'd8, 1'b0, 1'b0);
        step("lu_next", 5'd8, 5'd3, 1'b0, 5'd9, 1'b0, 1'b0);
        chk("lu_stall_cnt", int'(a_stall), 1);
        chk("lu_pc_free",   int'(a_pc),    1);

        // $0 destination never stalls.
        step("zero", 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
        step("zero_next", 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);
        chk("zero_stall_cnt", int'(a_stall), 1);

        // Single mult: three stall cycles then done on the fourth.
        apply_reset("rst_mul");
        for (int i = 0; i < 4; i++) step("mul", 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0);
        step("mul_after", 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);
        chk("mul_stall_cnt",   int'(a_stall), 3);
        chk("mul_lat1_stalls", int'(b_stall), 0);

        // Back-to-back mults, no idle cycle between them.
        for (int i = 0; i < 8; i++) step("mul_b2b", 5'd4, 5'd5, 1'b0, 5'd0, 1'b1, 1'b0);
        step("mul_b2b_after", 5'd4, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0);
        chk("b2b_stall_cnt", int'(a_stall), 9);

        // Taken branch alongside mult entry: flush wins, no MUL_WAIT.
        apply_reset("rst_br");
        step("br_mul",  5'd1, 5'd1, 1'b0, 5'd0, 1'b1, 1'b1);
        step("br_next", 5'd1, 5'd1, 1'b0, 5'd0, 1'b0, 1'b0);
        chk("br_flush_cnt", int'(a_flush), 1);
        chk("br_no_busy",   int'(a_busy),  0);

        // Reset asserted in the second MUL_WAIT cycle.
        apply_reset("rst_mid0");
        step("mid_entry", 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0);
        step("mid_w1",    5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0);
        step("mid_w2",    5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0);
        #1;
        rst_n = 1'b0;
        mult  = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_busy",  int'(a_busy),  0);
        chk("mid_rst_stall", int'(a_stall), 0);
        chk("mid_rst_ctl",   int'(flags_a()), int'(8'b1110_0000));
        @(negedge clk);
        rst_n = 1'b1;
        step("mid_after", 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);

        // Saturation: 20 load-use stalls into a 4-bit counter.
        apply_reset("rst_sat");
        for (int i = 0; i < 20; i++) step("sat", 5'd7, 5'd6, 1'b1, 5'd6, 1'b0, 1'b0);
        step("sat_after", 5'd7, 5'd6, 1'b0, 5'd6, 1'b0, 1'b0);
        chk("sat_b_stall", int'(b_stall), 15);
        chk("sat_a_stall", int'(a_stall), 20);

        // Randomized traffic with narrow register indices to force collisions.
        apply_reset("rst_rnd");
        for (int i = 0; i < 400; i++) begin
            bit [4:0] rr1, rr2, rwa;
            bit       rld, rmul, rbr;
            int       kind;
            rr1  = 5'($urandom_range(0, 3));
            rr2  = 5'($urandom_range(0, 3));
            rwa  = 5'($urandom_range(0, 3));
            kind = $urandom_range(0, 99);
            rld  = (kind < 35);
            rmul = (kind >= 35 && kind < 55);
            rbr  = ($urandom_range(0, 99) < 8);
            step("rnd", rr1, rr2, rld, rwa, rmul, rbr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
